pipe_reg_en: RTL

- Parametrised multi-stage pipeline register; the successor to the single enabled D flip-flop.
- Chains DEPTH word-wide stages. Each stage has its own valid bit.
- Upstream and downstream sides use valid/ready handshakes. Adds global stall (en), synchronous flush and bubble collapse.
- Sits between datapath stages of the CPU where a stall-able, flushable register slice is needed.

---
 rtl/pipe_reg_en.sv | 94 +++++++++
 1 files changed

// File: rtl/pipe_reg_en.sv
`default_nettype none
// ============================================================================
// pipe_reg_en : DEPTH-stage valid/ready register slice with stall, flush and
//               bubble collapse.
// Revision    : 1.0
// ============================================================================
module pipe_reg_en #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           d,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_v;

    logic [DEPTH-1:0] w_move;
    logic [DEPTH-1:0] w_accept;
    logic [WIDTH-1:0] w_in [DEPTH];
    logic             w_go;
    logic [CW-1:0]    w_count;

    assign w_go = en & ~flush;

    // Ready ripples back from the output: a stage may vacate if the next one
    // is empty or vacating itself, which is what collapses bubbles.
    always_comb begin
        w_move          = '0;
        w_move[DEPTH-1] = w_go & r_v[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_move[i] = w_go & r_v[i] & (~r_v[i+1] | w_move[i+1]);
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            if (g == 0) begin : g_head
                assign w_in[g]     = d;
                assign w_accept[g] = w_go & in_valid & (~r_v[0] | w_move[0]);
            end else begin : g_body
                assign w_in[g]     = r_data[g-1];
                assign w_accept[g] = w_move[g-1];
            end
        end
    endgenerate

    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + CW'(r_v[i]);
        end
    end

    // Flush drops only the valid bits; data registers keep their contents.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
        end else if (flush) begin
            r_v <= '0;
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_accept[i]) begin
                    r_data[i] <= w_in[i];
                    r_v[i]    <= 1'b1;
                end else if (w_move[i]) begin
                    r_v[i]    <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = clr & w_go & (~r_v[0] | w_move[0]);
    assign out_valid = r_v[DEPTH-1];
    assign q         = r_data[DEPTH-1];
    assign count     = w_count;

endmodule
`default_nettype wire
